// File: rtl/cv32e40x_aes_word_sequencer.sv
// Drives one AES32 column through four byte-select issues (bs 0..3) on an external AES unit and returns the final column.
// Optional macro AES_SEQ_ID_CHECK_EN adds a sticky result-tag mismatch flag reported on rsp_err_o.
module cv32e40x_aes_word_sequencer #(
  parameter int X_ID_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n,

  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_state_i,
  input  logic [31:0]           req_key_i,
  input  logic [1:0]            req_op_i,
  input  logic [X_ID_WIDTH-1:0] req_id_i,

  input  logic                  rnd_valid_i,
  output logic                  rnd_ready_o,
  input  logic [43:0]           rnd_i,

  output logic                  aes_valid_o,
  input  logic                  aes_ready_i,
  output logic [31:0]           aes_rs1_o,
  output logic [31:0]           aes_rs2_o,
  output logic [1:0]            aes_bs_o,
  output logic [7:0]            aes_mask_o,
  output logic [35:0]           aes_randombits_o,
  output logic [X_ID_WIDTH-1:0] aes_instr_id_o,
  output logic                  aes_op_encs_o,
  output logic                  aes_op_encsm_o,
  output logic                  aes_op_decs_o,
  output logic                  aes_op_decsm_o,

  input  logic                  aes_valid_i,
  output logic                  aes_ready_o,
  input  logic [31:0]           aes_result_i,
  input  logic [X_ID_WIDTH-1:0] aes_instr_id_i,

  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_data_o,
  output logic [X_ID_WIDTH-1:0] rsp_id_o,
  output logic                  rsp_err_o
);

  typedef enum logic [2:0] {IDLE, RND, ISSUE, WAIT, RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           r_acc;
  logic [31:0]           r_col;
  logic [1:0]            r_op;
  logic [X_ID_WIDTH-1:0] r_id;
  logic [1:0]            r_bs;
  logic [43:0]           r_rnd;
  // Low for the first cycle after reset so every output reads 0 right after a reset edge.
  logic                  r_live;

  logic w_req_fire;
  logic w_rnd_fire;
  logic w_res_fire;

  assign w_req_fire = req_valid_i & req_ready_o;
  assign w_rnd_fire = rnd_valid_i & rnd_ready_o;
  assign w_res_fire = aes_valid_i & aes_ready_o;

`ifdef AES_SEQ_ID_CHECK_EN
  logic r_err;
  logic w_id_mis;

  assign w_id_mis = (aes_instr_id_i != r_id);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_req_fire) begin
      r_err <= 1'b0;
    end else if (w_res_fire && w_id_mis) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused_id;

  assign w_unused_id = ^aes_instr_id_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
      r_acc   <= '0;
      r_col   <= '0;
      r_op    <= '0;
      r_id    <= '0;
      r_bs    <= '0;
      r_rnd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      if (w_req_fire) begin
        r_col <= req_state_i;
        r_op  <= req_op_i;
        r_id  <= req_id_i;
        r_acc <= req_key_i;
        r_bs  <= 2'd0;
      end
      if (w_rnd_fire) begin
        r_rnd <= rnd_i;
      end
      // bs_cnt stops at 3 on the last result so it never wraps inside a request.
      if (w_res_fire) begin
        r_acc <= aes_result_i;
        if (r_bs != 2'd3) begin
          r_bs <= r_bs + 2'd1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    req_ready_o      = 1'b0;
    rnd_ready_o      = 1'b0;
    aes_valid_o      = 1'b0;
    aes_rs1_o        = '0;
    aes_rs2_o        = '0;
    aes_bs_o         = '0;
    aes_mask_o       = '0;
    aes_randombits_o = '0;
    aes_instr_id_o   = '0;
    aes_op_encs_o    = 1'b0;
    aes_op_encsm_o   = 1'b0;
    aes_op_decs_o    = 1'b0;
    aes_op_decsm_o   = 1'b0;
    aes_ready_o      = 1'b0;
    rsp_valid_o      = 1'b0;
    rsp_data_o       = '0;
    rsp_id_o         = '0;
    rsp_err_o        = 1'b0;

    case (r_state)
      IDLE: begin
        req_ready_o = r_live;
        if (req_valid_i && r_live) begin
          w_state_nxt = RND;
        end
      end
      RND: begin
        rnd_ready_o = 1'b1;
        if (rnd_valid_i) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        aes_valid_o      = 1'b1;
        aes_rs1_o        = r_acc;
        aes_rs2_o        = r_col;
        aes_bs_o         = r_bs;
        aes_mask_o       = r_rnd[43:36];
        aes_randombits_o = r_rnd[35:0];
        aes_instr_id_o   = r_id;
        aes_op_encs_o    = (r_op == 2'b00);
        aes_op_encsm_o   = (r_op == 2'b01);
        aes_op_decs_o    = (r_op == 2'b10);
        aes_op_decsm_o   = (r_op == 2'b11);
        if (aes_ready_i) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        aes_ready_o = 1'b1;
        if (aes_valid_i) begin
          w_state_nxt = (r_bs == 2'd3) ? RESP : RND;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = r_acc;
        rsp_id_o    = r_id;
`ifdef AES_SEQ_ID_CHECK_EN
        rsp_err_o   = r_err;
`endif
        if (rsp_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule
